// File: rtl/mux_rr_reg.sv
// mux_rr_reg: N-channel multiplexer with a single registered output slot.
// Channels are granted either by an explicit index (mode 0) or by a
// round-robin search starting at rr_ptr (mode 1). The output slot is a
// two-state EMPTY/FULL stage that can drain and refill in the same cycle.
// Optional feature: define MUX_RR_GRANT_ID_EN to add output out_ch, the
// source channel index of the word held in out_data.
module mux_rr_reg #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4,
    parameter int SELW  = 2
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [NCH*WIDTH-1:0]  in_data,
    input  logic [NCH-1:0]        in_valid,
    output logic [NCH-1:0]        in_ready,
    input  logic [SELW-1:0]       sel,
    input  logic                  mode,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_valid,
    input  logic                  out_ready
`ifdef MUX_RR_GRANT_ID_EN
    ,
    output logic [SELW-1:0]       out_ch
`endif
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t            state;
    state_t            state_next;
    logic              load;
    logic              transfer;
    logic              grant_valid;
    logic [SELW-1:0]   grant_idx;
    logic [WIDTH-1:0]  grant_data;
    logic [SELW-1:0]   rr_ptr;
    logic [SELW-1:0]   rr_next;

    // The slot can accept a word when it is empty or is being emptied now.
    assign load     = (state == EMPTY) || out_ready;
    assign transfer = RESET && load && grant_valid;

    // Pick the granted channel: explicit index, or first valid at/after rr_ptr.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        if (mode == 1'b0) begin
            for (int i = 0; i < NCH; i++) begin
                if ((sel == SELW'(i)) && in_valid[i]) begin
                    grant_valid = 1'b1;
                    grant_idx   = SELW'(i);
                end
            end
        end else begin
            for (int i = NCH - 1; i >= 0; i--) begin
                if (in_valid[i] && (SELW'(i) < rr_ptr)) begin
                    grant_valid = 1'b1;
                    grant_idx   = SELW'(i);
                end
            end
            for (int i = NCH - 1; i >= 0; i--) begin
                if (in_valid[i] && (SELW'(i) >= rr_ptr)) begin
                    grant_valid = 1'b1;
                    grant_idx   = SELW'(i);
                end
            end
        end
    end

    // Route the granted channel's data towards the output register.
    always_comb begin
        grant_data = '0;
        for (int i = 0; i < NCH; i++) begin
            if (grant_idx == SELW'(i)) begin
                grant_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Acknowledge only the channel actually moving into the slot this cycle.
    always_comb begin
        in_ready = '0;
        for (int i = 0; i < NCH; i++) begin
            if (transfer && (grant_idx == SELW'(i))) begin
                in_ready[i] = 1'b1;
            end
        end
    end

    // Next round-robin start point is just past the channel granted.
    always_comb begin
        rr_next = '0;
        if (grant_idx != SELW'(NCH - 1)) begin
            rr_next = grant_idx + SELW'(1);
        end
    end

    // Output-slot state register.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Fill on a transfer, empty when the held word leaves with nothing behind it.
    always_comb begin
        state_next = state;
        if (transfer) begin
            state_next = FULL;
        end else if ((state == FULL) && out_ready) begin
            state_next = EMPTY;
        end
    end

    // The slot is valid exactly when it is full.
    always_comb begin
        out_valid = (state == FULL);
    end

    // Capture the granted word and advance the round-robin pointer.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            out_data <= '0;
            rr_ptr   <= '0;
        end else begin
            if (transfer) begin
                out_data <= grant_data;
            end
            if (transfer && mode) begin
                rr_ptr <= rr_next;
            end
        end
    end

`ifdef MUX_RR_GRANT_ID_EN
    // Remember which channel supplied the held word.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            out_ch <= '0;
        end else if (transfer) begin
            out_ch <= grant_idx;
        end
    end
`endif

endmodule

// File: tb/tb_mux_rr_reg.sv
// Testbench for mux_rr_reg: a 4-channel instance exercised through a
// scoreboard of expected output words, plus a 3-channel instance for
// round-robin wrap and out-of-range select. Define MUX_RR_GRANT_ID_EN to
// also check out_ch.
module tb_mux_rr_reg;

    localparam int WIDTH = 8;
    localparam int NCH   = 4;
    localparam int SELW  = 2;

    logic                 CLK = 1'b0;
    logic                 RESET;
    logic [NCH*WIDTH-1:0] in_data;
    logic [NCH-1:0]       in_valid;
    logic [NCH-1:0]       in_ready;
    logic [SELW-1:0]      sel;
    logic                 mode;
    logic [WIDTH-1:0]     out_data;
    logic                 out_valid;
    logic                 out_ready;

    logic [3*WIDTH-1:0]   b_in_data;
    logic [2:0]           b_in_valid;
    logic [2:0]           b_in_ready;
    logic [1:0]           b_sel;
    logic                 b_mode;
    logic [WIDTH-1:0]     b_out_data;
    logic                 b_out_valid;
    logic                 b_out_ready;

`ifdef MUX_RR_GRANT_ID_EN
    logic [SELW-1:0]      out_ch;
    logic [1:0]           b_out_ch;
`endif

    int passed = 0;
    int total  = 0;

    logic [WIDTH-1:0] sb[$];
    logic [WIDTH-1:0] pend[$];
    logic [WIDTH-1:0] bq[$];
    logic [1:0]       bch[$];
    logic             exp_valid;

    mux_rr_reg #(.WIDTH(WIDTH), .NCH(NCH), .SELW(SELW)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sel       (sel),
        .mode      (mode),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef MUX_RR_GRANT_ID_EN
        ,
        .out_ch    (out_ch)
`endif
    );

    mux_rr_reg #(.WIDTH(WIDTH), .NCH(3), .SELW(2)) dut3 (
        .CLK       (CLK),
        .RESET     (RESET),
        .in_data   (b_in_data),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .sel       (b_sel),
        .mode      (b_mode),
        .out_data  (b_out_data),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready)
`ifdef MUX_RR_GRANT_ID_EN
        ,
        .out_ch    (b_out_ch)
`endif
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    // Advance one cycle; at the falling edge compare the 4-channel output
    // against the scoreboard, then leave inputs free to change at posedge+3.
    task automatic tick();
        @(negedge CLK);
        exp_valid = (sb.size() != 0);
        total++;
        if (out_valid !== exp_valid) begin
            $display("[TB] FAIL sb_out_valid: got %b required %b", out_valid, exp_valid);
        end else begin
            passed++;
        end
        if (exp_valid && (out_valid === 1'b1)) begin
            total++;
            if (out_data !== sb[0]) begin
                $display("[TB] FAIL sb_out_data: got %h required %h", out_data, sb[0]);
            end else begin
                passed++;
            end
            if (out_ready === 1'b1) begin
                void'(sb.pop_front());
            end
        end
        if (RESET === 1'b0) begin
            sb.delete();
            pend.delete();
        end else begin
            while (pend.size() != 0) begin
                sb.push_back(pend.pop_front());
            end
        end
        @(posedge CLK);
        #3;
    endtask

    task automatic set_ch(input int ch, input logic [WIDTH-1:0] d);
        in_data[ch*WIDTH +: WIDTH] = d;
    endtask

    task automatic test_reset();
        RESET     = 1'b0;
        mode      = 1'b1;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        #1;
        total++;
        if (in_ready !== 4'b0000) begin
            $display("[TB] FAIL reset_in_ready: got %b required 0000", in_ready);
        end else begin
            passed++;
        end
        tick();
        #1;
        total++;
        if ((out_data !== 8'h00) || (out_valid !== 1'b0) || (in_ready !== 4'b0000)) begin
            $display("[TB] FAIL reset_state: got data=%h valid=%b ready=%b required 00/0/0000",
                     out_data, out_valid, in_ready);
        end else begin
            passed++;
        end
        tick();
    endtask

    task automatic test_explicit();
        RESET     = 1'b1;
        mode      = 1'b0;
        sel       = 2'd2;
        in_valid  = 4'b0100;
        set_ch(2, 8'hA5);
        out_ready = 1'b1;
        #1;
        total++;
        if (in_ready !== 4'b0100) begin
            $display("[TB] FAIL explicit_ready: got %b required 0100", in_ready);
        end else begin
            passed++;
        end
        pend.push_back(8'hA5);
        tick();
        in_valid = 4'b0000;
        #1;
        total++;
        if ((out_data !== 8'hA5) || (out_valid !== 1'b1)) begin
            $display("[TB] FAIL explicit_out: got %h/%b required a5/1", out_data, out_valid);
        end else begin
            passed++;
        end
        tick();
    endtask

    task automatic test_round_robin();
        logic [NCH-1:0] exp_ready;
        int g;
        mode      = 1'b1;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        for (int c = 0; c < NCH; c++) begin
            set_ch(c, 8'(8'h11 * (c + 1)));
        end
        for (int n = 0; n < 5; n++) begin
            g = n % NCH;
            exp_ready = '0;
            exp_ready[g] = 1'b1;
            #1;
            total++;
            if (in_ready !== exp_ready) begin
                $display("[TB] FAIL rr_grant%0d: got %b required %b", n, in_ready, exp_ready);
            end else begin
                passed++;
            end
            pend.push_back(in_data[g*WIDTH +: WIDTH]);
            tick();
        end
        in_valid = 4'b0000;
        tick();
    endtask

    task automatic test_stall();
        mode      = 1'b0;
        sel       = 2'd1;
        set_ch(1, 8'h3C);
        in_valid  = 4'b0010;
        out_ready = 1'b1;
        #1;
        total++;
        if (in_ready !== 4'b0010) begin
            $display("[TB] FAIL stall_load: got %b required 0010", in_ready);
        end else begin
            passed++;
        end
        pend.push_back(8'h3C);
        tick();
        for (int n = 0; n < 3; n++) begin
            out_ready = 1'b0;
            set_ch(1, 8'h5A);
            sel  = (n == 1) ? 2'd3 : 2'd1;
            mode = (n == 2);
            #1;
            total++;
            if ((in_ready !== 4'b0000) || (out_data !== 8'h3C)) begin
                $display("[TB] FAIL stall_hold%0d: got ready=%b data=%h required 0000/3c",
                         n, in_ready, out_data);
            end else begin
                passed++;
            end
            tick();
        end
        mode      = 1'b0;
        sel       = 2'd1;
        out_ready = 1'b1;
        #1;
        total++;
        if (in_ready !== 4'b0010) begin
            $display("[TB] FAIL stall_refill: got %b required 0010", in_ready);
        end else begin
            passed++;
        end
        pend.push_back(8'h5A);
        tick();
    endtask

    task automatic test_no_grant();
        mode      = 1'b0;
        sel       = 2'd3;
        in_valid  = 4'b0001;
        out_ready = 1'b1;
        #1;
        total++;
        if (in_ready !== 4'b0000) begin
            $display("[TB] FAIL nogrant_ready: got %b required 0000", in_ready);
        end else begin
            passed++;
        end
        tick();
        #1;
        total++;
        if ((in_ready !== 4'b0000) || (out_valid !== 1'b0)) begin
            $display("[TB] FAIL nogrant_drain: got ready=%b valid=%b required 0000/0",
                     in_ready, out_valid);
        end else begin
            passed++;
        end
        tick();
    endtask

    task automatic test_reset_mid();
        mode      = 1'b0;
        sel       = 2'd0;
        set_ch(0, 8'hFF);
        in_valid  = 4'b0001;
        out_ready = 1'b1;
        #1;
        total++;
        if (in_ready !== 4'b0001) begin
            $display("[TB] FAIL rstmid_load: got %b required 0001", in_ready);
        end else begin
            passed++;
        end
        pend.push_back(8'hFF);
        tick();
        RESET     = 1'b0;
        out_ready = 1'b0;
        mode      = 1'b1;
        in_valid  = 4'b1111;
        #1;
        total++;
        if (in_ready !== 4'b0000) begin
            $display("[TB] FAIL rstmid_ready: got %b required 0000", in_ready);
        end else begin
            passed++;
        end
        tick();
        RESET    = 1'b1;
        in_valid = 4'b0000;
        #1;
        total++;
        if ((out_data !== 8'h00) || (out_valid !== 1'b0)) begin
            $display("[TB] FAIL rstmid_clear: got %h/%b required 00/0", out_data, out_valid);
        end else begin
            passed++;
        end
        tick();
        mode      = 1'b1;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        set_ch(0, 8'h77);
        #1;
        total++;
        if (in_ready !== 4'b0001) begin
            $display("[TB] FAIL rstmid_ptr: got %b required 0001", in_ready);
        end else begin
            passed++;
        end
        pend.push_back(8'h77);
        tick();
        in_valid = 4'b0000;
        tick();
        tick();
    endtask

    task automatic test_wrap();
        logic [2:0] valid_tab [3];
        int         grant_tab [3];
        logic [2:0] exp_ready;
        logic [WIDTH-1:0] exp_data;
        logic [1:0] exp_ch;
        valid_tab[0] = 3'b001; grant_tab[0] = 0;
        valid_tab[1] = 3'b101; grant_tab[1] = 2;
        valid_tab[2] = 3'b101; grant_tab[2] = 0;
        b_mode      = 1'b1;
        b_sel       = 2'd0;
        b_out_ready = 1'b1;
        b_in_data   = {8'hC2, 8'hC1, 8'hC0};
        for (int n = 0; n < 3; n++) begin
            b_in_valid = valid_tab[n];
            exp_ready = '0;
            exp_ready[grant_tab[n]] = 1'b1;
            #1;
            total++;
            if (b_in_ready !== exp_ready) begin
                $display("[TB] FAIL wrap_grant%0d: got %b required %b", n, b_in_ready, exp_ready);
            end else begin
                passed++;
            end
            bq.push_back(b_in_data[grant_tab[n]*WIDTH +: WIDTH]);
            bch.push_back(2'(grant_tab[n]));
            tick();
            exp_data = bq.pop_front();
            exp_ch   = bch.pop_front();
            total++;
            if ((b_out_valid !== 1'b1) || (b_out_data !== exp_data)) begin
                $display("[TB] FAIL wrap_out%0d: got %h/%b required %h/1",
                         n, b_out_data, b_out_valid, exp_data);
            end else begin
                passed++;
            end
`ifdef MUX_RR_GRANT_ID_EN
            total++;
            if (b_out_ch !== exp_ch) begin
                $display("[TB] FAIL wrap_ch%0d: got %0d required %0d", n, b_out_ch, exp_ch);
            end else begin
                passed++;
            end
`endif
        end
        b_mode     = 1'b0;
        b_sel      = 2'd3;
        b_in_valid = 3'b111;
        #1;
        total++;
        if (b_in_ready !== 3'b000) begin
            $display("[TB] FAIL sel_range: got %b required 000", b_in_ready);
        end else begin
            passed++;
        end
        tick();
        total++;
        if (b_out_valid !== 1'b0) begin
            $display("[TB] FAIL sel_range_drain: got %b required 0", b_out_valid);
        end else begin
            passed++;
        end
        b_in_valid = 3'b000;
        tick();
    endtask

    initial begin
        RESET       = 1'b0;
        in_data     = '0;
        in_valid    = '0;
        sel         = '0;
        mode        = 1'b0;
        out_ready   = 1'b0;
        b_in_data   = '0;
        b_in_valid  = '0;
        b_sel       = '0;
        b_mode      = 1'b0;
        b_out_ready = 1'b0;
        $display("[TB] starting mux_rr_reg bench");
        test_reset();
        test_explicit();
        test_round_robin();
        test_stall();
        test_no_grant();
        test_reset_mid();
        test_wrap();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
